// File: rtl/branch_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_ctrl_if
// Redirect handshake between the branch resolution stage and instruction fetch.
//   redirect_valid  master -> slave  a redirect to redirect_pc is being offered
//   redirect_pc     master -> slave  target PC, held stable while valid
//   redirect_ready  slave -> master  IF accepts the redirect this cycle
// The branch stage is the master; IF is the slave.
// ---------------------------------------------------------------------------
interface branch_ctrl_if;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Branch resolution stage sitting right after the ID-stage RS/RT comparator.
// It turns the comparator flags and the decoded branch op into a taken /
// not-taken decision, waits for the MIPS delay-slot instruction to be fetched,
// then offers exactly one redirect to IF per taken branch. It also produces
// the GPR31 link write for BGEZAL/BLTZAL and keeps wrap-around statistics.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   id_fire         ID instruction valid and advancing this cycle
//   br_op           0 none, 1 BEQ, 2 BNE, 3 BGEZ, 4 BGTZ, 5 BLEZ, 6 BLTZ,
//                   7 BGEZAL, 8 BLTZAL, 9 J/JAL/JR, 10-15 none
//   cmp_ne          RS != RT
//   cmp_sign        00 RS==0, 10 RS<0, 01 RS>0 (11 is illegal)
//   br_target       resolved target PC
//   id_pc           PC of the branch in ID
//   ds_fetched      delay-slot instruction accepted by IF (level)
//   flush           exception / ERET flush from CP0
//   redir           redirect handshake to IF (master side)
//   br_busy         stall ID while a taken branch is outstanding
//   link_we         GPR31 link write strobe (combinational)
//   link_data       id_pc + 8
//   br_cnt          number of branch ops decided
//   taken_cnt       number of taken branches
// ---------------------------------------------------------------------------
module branch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_fire,
    input  logic [3:0]         br_op,
    input  logic               cmp_ne,
    input  logic [1:0]         cmp_sign,
    input  logic [31:0]        br_target,
    input  logic [31:0]        id_pc,
    input  logic               ds_fetched,
    input  logic               flush,
    branch_ctrl_if.master      redir,
    output logic               br_busy,
    output logic               link_we,
    output logic [31:0]        link_data,
    output logic [CNT_W-1:0]   br_cnt,
    output logic [CNT_W-1:0]   taken_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DS = 2'd1,
        REDIR   = 2'd2
    } state_t;

    state_t       state;
    logic         redirect_valid_q;
    logic [31:0]  redirect_pc_q;
    logic         is_branch;
    logic         decide;
    logic         taken;

    // A branch is only decided while no earlier taken branch is outstanding;
    // ID is expected to hold the instruction while br_busy is high.
    assign is_branch = (br_op >= 4'd1) && (br_op <= 4'd9);
    assign decide    = id_fire && (state == IDLE) && is_branch;

    // Taken evaluation from the comparator flags. cmp_sign==11 matches none
    // of the sign patterns, so every sign-based op falls to not-taken.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            4'd1:       taken = ~cmp_ne;
            4'd2:       taken = cmp_ne;
            4'd3, 4'd7: taken = (cmp_sign == 2'b00) || (cmp_sign == 2'b01);
            4'd4:       taken = (cmp_sign == 2'b01);
            4'd5:       taken = (cmp_sign == 2'b00) || (cmp_sign == 2'b10);
            4'd6, 4'd8: taken = (cmp_sign == 2'b10);
            4'd9:       taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

    // Link write happens for the and-link forms whether or not they branch.
    assign link_we   = decide && ((br_op == 4'd7) || (br_op == 4'd8));
    assign link_data = id_pc + 32'd8;

    assign br_busy              = (state != IDLE);
    assign redir.redirect_valid = redirect_valid_q;
    assign redir.redirect_pc    = redirect_pc_q;

    // Control FSM and statistics. Flush overrides everything except reset:
    // it abandons any outstanding redirect and suppresses counting of a
    // branch decided in the same cycle, but leaves the counters intact.
    // redirect_pc is only written on a taken decide, which can only occur in
    // IDLE, so it cannot move while the redirect is being offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            br_cnt           <= '0;
            taken_cnt        <= '0;
        end else if (flush) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (decide) begin
                        br_cnt <= br_cnt + 1'b1;
                        if (taken) begin
                            taken_cnt     <= taken_cnt + 1'b1;
                            redirect_pc_q <= br_target;
                            if (ds_fetched) begin
                                state            <= REDIR;
                                redirect_valid_q <= 1'b1;
                            end else begin
                                state <= WAIT_DS;
                            end
                        end
                    end
                end
                WAIT_DS: begin
                    if (ds_fetched) begin
                        state            <= REDIR;
                        redirect_valid_q <= 1'b1;
                    end
                end
                REDIR: begin
                    if (redir.redirect_ready) begin
                        state            <= IDLE;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl. Inputs change shortly after each rising
// edge; per-cycle outputs and redirect handshakes are sampled on the falling
// edge. A behavioural model describes the outstanding taken branch as a small
// record and pushes each expected redirect target into a queue; a separate
// monitor pops that queue whenever the DUT completes a redirect handshake.
// Counters are built narrow so that wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_fire;
    logic [3:0]        br_op;
    logic              cmp_ne;
    logic [1:0]        cmp_sign;
    logic [31:0]       br_target;
    logic [31:0]       id_pc;
    logic              ds_fetched;
    logic              flush;
    logic              br_busy;
    logic              link_we;
    logic [31:0]       link_data;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    branch_ctrl_if rif ();

    branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_fire    (id_fire),
        .br_op      (br_op),
        .cmp_ne     (cmp_ne),
        .cmp_sign   (cmp_sign),
        .br_target  (br_target),
        .id_pc      (id_pc),
        .ds_fetched (ds_fetched),
        .flush      (flush),
        .redir      (rif),
        .br_busy    (br_busy),
        .link_we    (link_we),
        .link_data  (link_data),
        .br_cnt     (br_cnt),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an outstanding taken branch (pending), whether its
    // delay slot has been fetched (ds_done), the last latched target and the
    // statistics as plain integers.
    bit          m_pending, n_pending;
    bit          m_ds_done, n_ds_done;
    logic [31:0] m_pc, n_pc;
    int          m_br, n_br;
    int          m_taken, n_taken;
    bit          e_link_we;
    logic [31:0] e_link_data;

    logic [31:0] expq[$];
    int          total_checks  = 0;
    int          passed_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Architectural meaning of each branch: compare RS against RT or zero.
    function automatic bit ref_taken(input int op, input bit ne, input int sign);
        bit rs_zero, rs_neg, rs_pos;
        rs_zero = (sign == 0);
        rs_pos  = (sign == 1);
        rs_neg  = (sign == 2);
        case (op)
            1:       return !ne;
            2:       return ne;
            3, 7:    return rs_zero || rs_pos;
            4:       return rs_pos;
            5:       return rs_zero || rs_neg;
            6, 8:    return rs_neg;
            9:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input bit r, input bit f, input bit fire, input int op,
                                 input bit ne, input int sg, input logic [31:0] tgt,
                                 input logic [31:0] pc, input bit ds, input bit rdy);
        bit is_br;
        rst                 = r;
        flush               = f;
        id_fire             = fire;
        br_op               = 4'(op);
        cmp_ne              = ne;
        cmp_sign            = 2'(sg);
        br_target           = tgt;
        id_pc               = pc;
        ds_fetched          = ds;
        rif.redirect_ready  = rdy;

        is_br       = (op >= 1) && (op <= 9);
        e_link_we   = fire && !m_pending && (op == 7 || op == 8);
        e_link_data = pc + 32'd8;

        n_pending = m_pending;
        n_ds_done = m_ds_done;
        n_pc      = m_pc;
        n_br      = m_br;
        n_taken   = m_taken;
        if (r) begin
            n_pending = 0; n_ds_done = 0; n_pc = 32'd0; n_br = 0; n_taken = 0;
        end else if (f) begin
            n_pending = 0; n_ds_done = 0;
        end else if (m_pending && m_ds_done) begin
            if (rdy) begin
                expq.push_back(m_pc);
                n_pending = 0; n_ds_done = 0;
            end
        end else if (m_pending) begin
            if (ds) n_ds_done = 1;
        end else if (fire && is_br) begin
            n_br = (m_br + 1) % CNT_MOD;
            if (ref_taken(op, ne, sg)) begin
                n_taken   = (m_taken + 1) % CNT_MOD;
                n_pending = 1;
                n_ds_done = ds;
                n_pc      = tgt;
            end
        end
    endtask

    task automatic checkOutput();
        check("redirect_valid", 32'(rif.redirect_valid), 32'(m_pending && m_ds_done));
        check("br_busy",        32'(br_busy),            32'(m_pending));
        check("redirect_pc",    rif.redirect_pc,         m_pc);
        check("br_cnt",         32'(br_cnt),             32'(m_br));
        check("taken_cnt",      32'(taken_cnt),          32'(m_taken));
        check("link_we",        32'(link_we),            32'(e_link_we));
        check("link_data",      link_data,               e_link_data);
    endtask

    task automatic runCycle(input bit r, input bit f, input bit fire, input int op,
                            input bit ne, input int sg, input logic [31:0] tgt,
                            input logic [31:0] pc, input bit ds, input bit rdy);
        @(posedge clk);
        #1;
        m_pending = n_pending;
        m_ds_done = n_ds_done;
        m_pc      = n_pc;
        m_br      = n_br;
        m_taken   = n_taken;
        applyStimulus(r, f, fire, op, ne, sg, tgt, pc, ds, rdy);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycle(input bit ds, input bit rdy);
        runCycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, ds, rdy);
    endtask

    // Monitor: every accepted redirect must match the next expected target.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 &&
            rif.redirect_valid === 1'b1 && rif.redirect_ready === 1'b1) begin
            if (expq.size() == 0) check("redirect_unexpected", 32'd1, 32'd0);
            else check("redirect_hs_pc", rif.redirect_pc, expq.pop_front());
        end
    end

    initial begin
        m_pending = 0; m_ds_done = 0; m_pc = 0; m_br = 0; m_taken = 0;
        n_pending = 0; n_ds_done = 0; n_pc = 0; n_br = 0; n_taken = 0;
        rst = 1'b1; flush = 1'b0; id_fire = 1'b0; br_op = 4'd0; cmp_ne = 1'b0;
        cmp_sign = 2'b00; br_target = 32'h0; id_pc = 32'h0; ds_fetched = 1'b0;
        rif.redirect_ready = 1'b0;
        @(posedge clk);

        // Reset state observed while reset is still held.
        runCycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // BEQ taken with delay slot already fetched, accepted immediately.
        runCycle(0, 0, 1, 1, 0, 0, 32'h0000_1000, 32'h0000_0080, 1, 1);
        idleCycle(0, 1);
        idleCycle(0, 1);

        // BNE with equal operands: not taken.
        runCycle(0, 0, 1, 2, 0, 0, 32'h0000_2000, 32'h0000_0090, 1, 1);
        idleCycle(0, 0);

        // BGTZ taken, delay slot late by three cycles, IF stalls five cycles.
        runCycle(0, 0, 1, 4, 0, 1, 32'h0000_3000, 32'h0000_00A0, 0, 0);
        for (int i = 0; i < 3; i++) idleCycle(0, 0);
        idleCycle(1, 0);
        for (int i = 0; i < 5; i++) runCycle(0, 0, 1, 9, 0, 0, 32'hDEAD_0000, 32'h0, 1, 0);
        idleCycle(0, 1);
        idleCycle(0, 0);

        // BLTZAL with RS>0 links but does not branch; BLEZ with illegal sign.
        runCycle(0, 0, 1, 8, 0, 1, 32'h0000_4000, 32'hBFC0_0010, 1, 1);
        runCycle(0, 0, 1, 5, 0, 3, 32'h0000_5000, 32'hBFC0_0014, 1, 1);
        idleCycle(0, 0);

        // Flush while waiting for the delay slot and while offering the
        // redirect, each time with a new branch presented in the flush cycle.
        runCycle(0, 0, 1, 1, 0, 0, 32'h0000_6000, 32'h0000_0100, 0, 0);
        runCycle(0, 1, 1, 1, 0, 0, 32'h0000_6100, 32'h0000_0104, 0, 0);
        runCycle(0, 1, 1, 9, 0, 0, 32'h0000_6200, 32'h0000_0108, 1, 1);
        runCycle(0, 0, 1, 3, 0, 0, 32'h0000_7000, 32'h0000_0110, 1, 0);
        runCycle(0, 1, 1, 7, 0, 0, 32'h0000_7100, 32'h0000_0114, 1, 1);
        idleCycle(0, 1);

        // Reset in the middle of an offered redirect.
        runCycle(0, 0, 1, 9, 0, 0, 32'h0000_8000, 32'h0000_0120, 1, 0);
        idleCycle(0, 0);
        runCycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
        idleCycle(0, 0);

        // Randomised traffic; the narrow counters wrap many times.
        for (int i = 0; i < 3000; i++) begin
            runCycle(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 15) == 0),
                     $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 15)),
                     $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2)),
                     $urandom(),
                     $urandom(),
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 2) != 0);
        end
        idleCycle(1, 1);
        idleCycle(1, 1);
        @(negedge clk);

        check("expected_redirects_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
